// File: rtl/vga_layer_scheduler.sv
// ---------------------------------------------------------------------------
// vga_layer_scheduler
//
// Composites four rectangular, solid-colour sprite layers (0 = dino,
// 1 = obstacle, 2 = ground, 3 = score; lower index wins) onto the pixel
// stream of a 640x480 VGA timing generator. Game logic loads layer configs
// into shadow registers. A commit request copies all shadow registers into
// the active set at the next vblank start, so a visible frame never tears.
// A per-frame layer0/layer1 overlap flag is also reported.
//
// Ports
//   pixel_clk, rst              pixel clock, async active-high reset
//   hcounter, vcounter          timing generator counters
//   hs_in, vs_in, blank_in      timing generator strobes, 1 cycle behind counters
//   cfg_valid/cfg_ready         config write handshake
//   cfg_layer, cfg_x, cfg_y,
//   cfg_w, cfg_h, cfg_color,
//   cfg_en                      config write payload
//   commit_req                  pulse: apply shadow regs at next vblank start
//   commit_done                 1-cycle pulse when the active regs update
//   frame_start                 1-cycle pulse, 1 cycle after (h==0, v==VLINES)
//   collide                     layer0/layer1 overlap seen in the previous frame
//   rgb, hs_out, vs_out         composited pixel and aligned syncs (2 cycles)
//   dbg_state                   config FSM state (0 OPEN, 1 PENDING, 2 COMMIT)
//
// Handshake: a config word transfers on every rising edge where cfg_valid
// and cfg_ready are both high. cfg_ready depends only on the FSM state, never
// on cfg_valid; the producer may hold cfg_valid and the payload stable for as
// long as cfg_ready stays low.
// ---------------------------------------------------------------------------
module vga_layer_scheduler #(
  parameter int          HLINES   = 640,
  parameter int          VLINES   = 480,
  parameter int          CW       = 11,
  parameter logic [11:0] BG_COLOR = 12'hFFF
) (
  input  logic          pixel_clk,
  input  logic          rst,
  input  logic [CW-1:0] hcounter,
  input  logic [CW-1:0] vcounter,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          blank_in,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [1:0]    cfg_layer,
  input  logic [CW-1:0] cfg_x,
  input  logic [CW-1:0] cfg_y,
  input  logic [CW-1:0] cfg_w,
  input  logic [CW-1:0] cfg_h,
  input  logic [11:0]   cfg_color,
  input  logic          cfg_en,
  input  logic          commit_req,
  output logic          commit_done,
  output logic          frame_start,
  output logic          collide,
  output logic [11:0]   rgb,
  output logic          hs_out,
  output logic          vs_out,
  output logic [1:0]    dbg_state
);

  typedef struct packed {
    logic          en;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [CW-1:0] w;
    logic [CW-1:0] h;
    logic [11:0]   color;
  } layer_t;

  typedef enum logic [1:0] {
    ST_OPEN    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  layer_t      shadow_q [4];
  layer_t      active_q [4];
  layer_t      cfg_word;
  logic [3:0]  hit_q, hit_d;
  logic        vis_q, vis_d;
  logic        sticky_q, sticky_d;
  logic        collide_q, collide_d;
  logic        fs_q;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, vs_q;
  logic        vb_start;
  logic        cfg_fire;
  logic        coll_now;
  logic [CW:0] h_ext, v_ext;

  assign vb_start = (hcounter == '0) && (vcounter == CW'(VLINES));
  assign cfg_fire = cfg_valid && cfg_ready;
  assign cfg_word = {cfg_en, cfg_x, cfg_y, cfg_w, cfg_h, cfg_color};

  // ---------------- config FSM ----------------
  always_comb begin
    state_d     = state_q;
    cfg_ready   = 1'b0;
    commit_done = 1'b0;
    unique case (state_q)
      ST_OPEN: begin
        cfg_ready = 1'b1;
        if (commit_req) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (vb_start) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit_done = 1'b1;
        state_d     = ST_OPEN;
      end
      default: state_d = ST_OPEN;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) state_q <= ST_OPEN;
    else     state_q <= state_d;
  end

  assign dbg_state = state_q;

  // Shadow takes handshake writes; active copies the whole shadow set in the
  // single COMMIT cycle, which always falls inside vblank.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (cfg_fire) shadow_q[cfg_layer] <= cfg_word;
      if (state_q == ST_COMMIT) begin
        for (int i = 0; i < 4; i++) active_q[i] <= shadow_q[i];
      end
    end
  end

  // ---------------- stage 1: hit test ----------------
  // Bounds are compared at CW+1 bits so x+w / y+h past the counter range
  // cannot wrap around to the left or top edge.
  assign h_ext = {1'b0, hcounter};
  assign v_ext = {1'b0, vcounter};

  always_comb begin
    hit_d = '0;
    for (int i = 0; i < 4; i++) begin
      hit_d[i] = active_q[i].en
        && (h_ext >= {1'b0, active_q[i].x})
        && (h_ext <  ({1'b0, active_q[i].x} + {1'b0, active_q[i].w}))
        && (v_ext >= {1'b0, active_q[i].y})
        && (v_ext <  ({1'b0, active_q[i].y} + {1'b0, active_q[i].h}));
    end
  end

  assign vis_d = (hcounter < CW'(HLINES)) && (vcounter < CW'(VLINES));

  // ---------------- stage 2: priority mux ----------------
  // Colour is read from active_q one cycle after the hit test; the two can
  // only disagree around COMMIT, where blank forces rgb to 0 anyway.
  always_comb begin
    rgb_d = BG_COLOR;
    for (int i = 3; i >= 0; i--) begin
      if (hit_q[i]) rgb_d = active_q[i].color;
    end
    if (blank_in) rgb_d = '0;
  end

  // ---------------- collision ----------------
  // The pixel still in stage 1 at vblank start is folded into the latched
  // value rather than being lost to the clear.
  assign coll_now = hit_q[0] && hit_q[1] && vis_q;

  always_comb begin
    sticky_d  = sticky_q | coll_now;
    collide_d = collide_q;
    if (vb_start) begin
      collide_d = sticky_q | coll_now;
      sticky_d  = 1'b0;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      hit_q     <= '0;
      vis_q     <= 1'b0;
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      fs_q      <= 1'b0;
      sticky_q  <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      hit_q     <= hit_d;
      vis_q     <= vis_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_in;
      vs_q      <= vs_in;
      fs_q      <= vb_start;
      sticky_q  <= sticky_d;
      collide_q <= collide_d;
    end
  end

  assign rgb         = rgb_q;
  assign hs_out      = hs_q;
  assign vs_out      = vs_q;
  assign frame_start = fs_q;
  assign collide     = collide_q;

endmodule

// File: tb/tb_vga_layer_scheduler.sv
// ---------------------------------------------------------------------------
// Bench for vga_layer_scheduler. The bench plays the timing generator with a
// shortened frame: each line is 660 pixels (640 visible + 20 blank, HS low
// at h648..655) and a frame visits only lines 199, 200, 209, 210, 480
// (vblank start) and 481 (VS low). Every driven pixel pushes its expected
// {hs,vs,rgb} into exp_q; it is popped two cycles later when the DUT shows it.
// A behavioural model of the shadow/active registers and the config state
// supplies the per-cycle frame_start / commit_done / cfg_ready / collide /
// state expectations.
// ---------------------------------------------------------------------------
module tb_vga_layer_scheduler;

  localparam int W    = 14;
  localparam int HL   = 640;
  localparam int VL   = 480;
  localparam int HTOT = 660;

  // clock / reset
  logic pixel_clk = 1'b0;
  logic rst = 1'b0;
  always #20 pixel_clk = ~pixel_clk;

  // DUT signals
  logic [10:0] hcounter, vcounter;
  logic        hs_in, vs_in, blank_in;
  logic        cfg_valid, cfg_ready;
  logic [1:0]  cfg_layer;
  logic [10:0] cfg_x, cfg_y, cfg_w, cfg_h;
  logic [11:0] cfg_color;
  logic        cfg_en, commit_req;
  logic        commit_done, frame_start, collide;
  logic [11:0] rgb;
  logic        hs_out, vs_out;
  logic [1:0]  dbg_state;

  vga_layer_scheduler dut (
    .pixel_clk(pixel_clk), .rst(rst),
    .hcounter(hcounter), .vcounter(vcounter),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_layer(cfg_layer),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_color(cfg_color), .cfg_en(cfg_en), .commit_req(commit_req),
    .commit_done(commit_done), .frame_start(frame_start), .collide(collide),
    .rgb(rgb), .hs_out(hs_out), .vs_out(vs_out), .dbg_state(dbg_state)
  );

  // scoreboard / model state
  typedef struct {
    bit en;
    int x, y, w, h, c;
  } lay_t;

  logic [W-1:0] exp_q[$];
  lay_t sh_m [4];
  lay_t act_m [4];
  int   m_state;
  bit   sticky_m, exp_col, exp_fs, exp_cd, exp_rdy;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   cd_seen = 0;
  int   cur_h, cur_v, li;
  int   lines [6] = '{199, 200, 209, 210, 480, 481};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit hit_m(int i, int h, int v);
    return act_m[i].en && h >= act_m[i].x && h < act_m[i].x + act_m[i].w &&
           v >= act_m[i].y && v < act_m[i].y + act_m[i].h;
  endfunction

  function automatic logic [W-1:0] exp_pixel(int h, int v);
    logic [11:0] c;
    logic hs, vs;
    hs = !(h >= 648 && h < 656);
    vs = (v != 481);
    if (h >= HL || v >= VL) c = 12'h000;
    else if (hit_m(0, h, v)) c = 12'(act_m[0].c);
    else if (hit_m(1, h, v)) c = 12'(act_m[1].c);
    else if (hit_m(2, h, v)) c = 12'(act_m[2].c);
    else if (hit_m(3, h, v)) c = 12'(act_m[3].c);
    else c = 12'hFFF;
    return {hs, vs, c};
  endfunction

  // Model of what the DUT does at the coming rising edge, given the inputs
  // currently driven.
  task automatic model_edge();
    bit vb;
    vb = (cur_h == 0 && cur_v == VL);
    exp_fs = vb;
    if (vb) begin
      exp_col  = sticky_m;
      sticky_m = 1'b0;
    end
    case (m_state)
      0: begin
        if (cfg_valid) begin
          sh_m[cfg_layer].en = cfg_en;
          sh_m[cfg_layer].x  = int'(cfg_x);
          sh_m[cfg_layer].y  = int'(cfg_y);
          sh_m[cfg_layer].w  = int'(cfg_w);
          sh_m[cfg_layer].h  = int'(cfg_h);
          sh_m[cfg_layer].c  = int'(cfg_color);
        end
        if (commit_req) m_state = 1;
      end
      1: if (vb) m_state = 2;
      default: begin
        for (int i = 0; i < 4; i++) act_m[i] = sh_m[i];
        m_state = 0;
      end
    endcase
    exp_cd  = (m_state == 2);
    exp_rdy = (m_state == 0);
  endtask

  // driver: one pixel clock
  task automatic step();
    logic [W-1:0] e;
    model_edge();
    @(posedge pixel_clk);
    #1;
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      check("pixel", 16'({hs_out, vs_out, rgb}), 16'(e));
    end
    check("frame_start", 16'(frame_start), 16'(exp_fs));
    check("commit_done", 16'(commit_done), 16'(exp_cd));
    check("cfg_ready", 16'(cfg_ready), 16'(exp_rdy));
    check("collide", 16'(collide), 16'(exp_col));
    check("state", 16'(dbg_state), 16'(m_state));
    if (commit_done) cd_seen++;
    // strobes trail the counters by one cycle
    hs_in    = !(cur_h >= 648 && cur_h < 656);
    vs_in    = (cur_v != 481);
    blank_in = (cur_h >= HL || cur_v >= VL);
    if (cur_h == HTOT - 1) begin
      cur_h = 0;
      li    = (li + 1) % 6;
    end else begin
      cur_h++;
    end
    cur_v    = lines[li];
    hcounter = 11'(cur_h);
    vcounter = 11'(cur_v);
    exp_q.push_back(exp_pixel(cur_h, cur_v));
    if (cur_h < HL && cur_v < VL && hit_m(0, cur_h, cur_v) && hit_m(1, cur_h, cur_v))
      sticky_m = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_rgb", 16'(rgb), 16'h000);
    check("rst_hs_out", 16'(hs_out), 16'h1);
    check("rst_vs_out", 16'(vs_out), 16'h1);
    check("rst_cfg_ready", 16'(cfg_ready), 16'h1);
    check("rst_commit_done", 16'(commit_done), 16'h0);
    check("rst_frame_start", 16'(frame_start), 16'h0);
    check("rst_collide", 16'(collide), 16'h0);
    check("rst_state", 16'(dbg_state), 16'h0);
    m_state = 0;
    for (int i = 0; i < 4; i++) begin
      sh_m[i]  = '{0, 0, 0, 0, 0, 0};
      act_m[i] = '{0, 0, 0, 0, 0, 0};
    end
    sticky_m = 1'b0;
    exp_col  = 1'b0;
    exp_fs   = 1'b0;
    exp_cd   = 1'b0;
    exp_rdy  = 1'b1;
    exp_q.delete();
    @(posedge pixel_clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_cfg(input int l, input int x, input int y, input int w, input int h,
                         input int c, input bit en);
    cfg_layer = 2'(l);
    cfg_x     = 11'(x);
    cfg_y     = 11'(y);
    cfg_w     = 11'(w);
    cfg_h     = 11'(h);
    cfg_color = 12'(c);
    cfg_en    = en;
  endtask

  task automatic write_layer(input int l, input int x, input int y, input int w, input int h,
                             input int c, input bit en);
    set_cfg(l, x, y, w, h, c, en);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
  endtask

  // run until the counters return to line 199, h0 (at least one step)
  task automatic to_frame_start();
    step();
    for (int i = 0; i < 4000; i++) begin
      if (li == 0 && cur_h == 0) break;
      step();
    end
  endtask

  // run until the vblank-start pixel is the one being driven
  task automatic to_vb_drive();
    for (int i = 0; i < 4000; i++) begin
      if (li == 4 && cur_h == 0) break;
      step();
    end
  endtask

  initial begin
    int  cd0;
    bit  got;
    cur_h = 0; li = 0; cur_v = lines[0];
    hcounter = 11'(cur_h); vcounter = 11'(cur_v);
    hs_in = 1'b1; vs_in = 1'b1; blank_in = 1'b0;
    cfg_valid = 1'b0; commit_req = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 1'b0);
    #3;

    // 1: reset, nothing configured: background in visible area, 0 in blank
    do_reset();
    to_frame_start();

    // 2: single layer on L1, committed at vblank, visible next frame
    cd0 = cd_seen;
    write_layer(1, 100, 200, 20, 10, 12'h0F0, 1'b1);
    pulse_commit();
    to_frame_start();
    check("t2_commit_once", 16'(cd_seen - cd0), 16'd1);
    to_frame_start();
    check("t2_no_collide", 16'(collide), 16'h0);

    // 3: overlapping L0/L1, L0 wins, collision latched at frame_start
    write_layer(0, 100, 200, 10, 10, 12'hF00, 1'b1);
    write_layer(1, 105, 200, 20, 10, 12'h0F0, 1'b1);
    pulse_commit();
    to_frame_start();
    to_frame_start();
    check("t3_collide", 16'(collide), 16'h1);

    // 4: write in the commit_req cycle is included; a held write during
    //    PENDING waits until the cycle after commit_done
    set_cfg(0, 300, 200, 5, 10, 12'h00F, 1'b1);
    cfg_valid  = 1'b1;
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    set_cfg(2, 400, 209, 8, 2, 12'hFF0, 1'b1);
    step();
    check("t4_ready_pending", 16'(cfg_ready), 16'h0);
    pulse_commit();
    got = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (commit_done) begin
        got = 1'b1;
        break;
      end
    end
    check("t4_commit_seen", 16'(got), 16'h1);
    step();
    check("t4_ready_after", 16'(cfg_ready), 16'h1);
    step();
    cfg_valid = 1'b0;
    pulse_commit();
    to_frame_start();
    to_frame_start();

    // 5: right-edge clip, no wrap, zero width/height, commit_req on the
    //    vblank-start cycle deferred by one frame
    write_layer(2, 630, 200, 20, 10, 12'h0FF, 1'b1);
    write_layer(3, 2040, 199, 20, 12, 12'hF0F, 1'b1);
    write_layer(0, 0, 199, 0, 12, 12'h111, 1'b1);
    write_layer(1, 0, 199, 640, 0, 12'h222, 1'b1);
    to_vb_drive();
    cd0 = cd_seen;
    pulse_commit();
    to_frame_start();
    check("t5_no_commit_same_vb", 16'(cd_seen - cd0), 16'd0);
    to_frame_start();
    check("t5_commit_next_vb", 16'(cd_seen - cd0), 16'd1);
    to_frame_start();

    // 6: reset while PENDING drops the commit
    write_layer(0, 50, 199, 100, 12, 12'h123, 1'b1);
    pulse_commit();
    for (int i = 0; i < 500; i++) step();
    check("t6_pending", 16'(dbg_state), 16'h1);
    do_reset();
    cd0 = cd_seen;
    to_frame_start();
    to_frame_start();
    check("t6_no_commit", 16'(cd_seen - cd0), 16'd0);
    check("t6_collide", 16'(collide), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
